// File: rtl/n64_ctrl_responder.sv
// -----------------------------------------------------------------------------
// n64_ctrl_responder
//
// Joybus controller-side responder. Watches the controller data line, decodes
// the console command byte and, when enabled, answers by pulling the line low
// (open-drain) with either the 24-bit identity reply (commands 0x00 / 0xFF) or
// the 32-bit button word (command 0x01). Everything runs from the 4 MHz
// controller clock: 1 us = 4 cycles, one joybus bit = 16 cycles.
//
// Wire format (both directions): a bit cell is 16 cycles, starting low.
//   '1' = 4 cycles low then 12 high, '0' = 12 cycles low then 4 high.
//
// Parameters
//   RESP_DELAY   high cycles between the console stop bit and our first drive
//   IDLE_MIN     high cycles required before a falling edge starts a command
//   STATUS_BYTE  third byte of the identity reply (0x02 = no pak)
//
// Ports
//   CLK_4M    in   sole clock, 4 MHz
//   RST       in   synchronous active-high reset
//   CTRL_IN   in   raw joybus line level, asynchronous to CLK_4M
//   CTRL_OE   out  registered; 1 = pull line low, 0 = release
//   EN        in   0 = decode only, never drive
//   BTN_DATA  in   poll reply word, sent LSB first (bit0 = A button)
//   CMD       out  last decoded command byte
//   CMD_STB   out  one-cycle pulse whenever CMD updates
//   BUSY      out  high from the first reply drive through stop-bit release
// -----------------------------------------------------------------------------
module n64_ctrl_responder #(
    parameter int         RESP_DELAY  = 8,
    parameter int         IDLE_MIN    = 16,
    parameter logic [7:0] STATUS_BYTE = 8'h02
) (
    input  logic        CLK_4M,
    input  logic        RST,
    input  logic        CTRL_IN,
    output logic        CTRL_OE,
    input  logic        EN,
    input  logic [31:0] BTN_DATA,
    output logic [7:0]  CMD,
    output logic        CMD_STB,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_RD,
        S_STOP_RD,
        S_DELAY,
        S_TX_LOW,
        S_TX_HIGH,
        S_TX_STOP
    } state_t;

    localparam logic [7:0] DELAY_LAST = 8'(RESP_DELAY - 1);
    localparam logic [5:0] IDLE_MIN_C = 6'(IDLE_MIN);
    localparam logic [7:0] STOP_LAST  = 8'd7;   // stop bit: 8 cycles low

    // Identity reply, left-justified so it shifts out from bit 31 like the
    // bit-reversed button word does.
    localparam logic [31:0] INFO_WORD = {8'h05, 8'h00, STATUS_BYTE, 8'h00};

    // ---------------------------------------------------------------------
    // Line input: synchronizer, edge detect, run-length counter
    // ---------------------------------------------------------------------
    logic       sync1;
    logic       sync2;
    logic       line_d;
    logic       fall;
    logic       rise;
    logic       edge_any;
    logic [5:0] cnt;
    logic       cnt_sat;
    logic       rx_bit;

    assign fall     = line_d & ~sync2;
    assign rise     = ~line_d & sync2;
    assign edge_any = fall | rise;
    assign cnt_sat  = &cnt;

    // On a rising edge cnt still holds the length of the low pulse just
    // ended (the counter clears on the next clock), so it is the decode
    // input directly.
    assign rx_bit = (cnt < 6'd8);

    // ---------------------------------------------------------------------
    // FSM and datapath registers
    // ---------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [7:0]  cmd_sr;
    logic [31:0] tx_sr;
    logic        tx_info;
    logic [4:0]  bcnt;
    logic [7:0]  tcnt;

    // Control strobes from the next-state logic into the datapath
    logic        cmd_shift;
    logic        bcnt_clr;
    logic        bcnt_inc;
    logic        tcnt_clr;
    logic        cnt_clr;
    logic        stb_next;
    logic        load_info;
    logic        load_poll;
    logic        tx_shift;
    logic        oe_next;
    logic        busy_next;

    logic [31:0] btn_rev;
    logic [7:0]  low_last;
    logic [7:0]  high_last;
    logic [4:0]  bit_last;

    // Button word goes out LSB first; reversing it lets both replies share
    // one MSB-first shifter.
    always_comb begin
        btn_rev = '0;
        for (int i = 0; i < 32; i++) begin
            btn_rev[i] = BTN_DATA[31 - i];
        end
    end

    // Low/high phase lengths (minus one) of the bit currently at tx_sr[31].
    assign low_last  = tx_sr[31] ? 8'd3  : 8'd11;
    assign high_last = tx_sr[31] ? 8'd11 : 8'd3;
    assign bit_last  = tx_info ? 5'd23 : 5'd31;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_next = state;
        cmd_shift  = 1'b0;
        bcnt_clr   = 1'b0;
        bcnt_inc   = 1'b0;
        tcnt_clr   = 1'b0;
        cnt_clr    = 1'b0;
        stb_next   = 1'b0;
        load_info  = 1'b0;
        load_poll  = 1'b0;
        tx_shift   = 1'b0;

        case (state)
            S_IDLE: begin
                // Short high gaps (payload bits of commands we do not answer)
                // never reach IDLE_MIN, so they cannot start a new command.
                if (fall && (cnt >= IDLE_MIN_C)) begin
                    state_next = S_CMD_RD;
                    bcnt_clr   = 1'b1;
                end
            end

            S_CMD_RD: begin
                if (rise) begin
                    cmd_shift = 1'b1;
                    bcnt_inc  = 1'b1;
                    if (bcnt == 5'd7) begin
                        state_next = S_STOP_RD;
                    end
                end else if (!edge_any && cnt_sat) begin
                    // An edge in the same cycle clears the counter, so it
                    // takes priority over the timeout.
                    state_next = S_IDLE;
                end
            end

            S_STOP_RD: begin
                if (rise) begin
                    stb_next = 1'b1;
                    tcnt_clr = 1'b1;
                    bcnt_clr = 1'b1;
                    if (EN && ((cmd_sr == 8'h00) || (cmd_sr == 8'hFF))) begin
                        load_info  = 1'b1;
                        state_next = S_DELAY;
                    end else if (EN && (cmd_sr == 8'h01)) begin
                        load_poll  = 1'b1;
                        state_next = S_DELAY;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (!edge_any && cnt_sat) begin
                    state_next = S_IDLE;
                end
            end

            S_DELAY: begin
                // Someone else pulled the line low: back off, never drive.
                if (fall) begin
                    state_next = S_IDLE;
                end else if (tcnt == DELAY_LAST) begin
                    state_next = S_TX_LOW;
                    tcnt_clr   = 1'b1;
                end
            end

            // From here until TX_STOP ends the line only reflects our own
            // drive, so input edges are not looked at.
            S_TX_LOW: begin
                if (tcnt == low_last) begin
                    state_next = S_TX_HIGH;
                    tcnt_clr   = 1'b1;
                end
            end

            S_TX_HIGH: begin
                if (tcnt == high_last) begin
                    tcnt_clr = 1'b1;
                    if (bcnt == bit_last) begin
                        state_next = S_TX_STOP;
                    end else begin
                        state_next = S_TX_LOW;
                        tx_shift   = 1'b1;
                        bcnt_inc   = 1'b1;
                    end
                end
            end

            S_TX_STOP: begin
                if (tcnt == STOP_LAST) begin
                    state_next = S_IDLE;
                    cnt_clr    = 1'b1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Drive and busy are decoded from the next state and registered, so
        // they change on exactly the edge the state does.
        oe_next   = (state_next == S_TX_LOW) || (state_next == S_TX_STOP);
        busy_next = (state_next == S_TX_LOW) || (state_next == S_TX_HIGH) ||
                    (state_next == S_TX_STOP);
    end

    always_ff @(posedge CLK_4M) begin
        if (RST) begin
            // NOTE: the synchronizer resets to the idle-high line level so
            // leaving reset does not fabricate a falling edge.
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            line_d  <= 1'b1;
            cnt     <= '0;
            state   <= S_IDLE;
            cmd_sr  <= '0;
            tx_sr   <= '0;
            tx_info <= 1'b0;
            bcnt    <= '0;
            tcnt    <= '0;
            CMD     <= 8'h00;
            CMD_STB <= 1'b0;
            CTRL_OE <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the values from before this clock edge.
            sync1  <= CTRL_IN;
            sync2  <= sync1;
            line_d <= sync2;

            if (edge_any || cnt_clr) begin
                cnt <= '0;
            end else if (!cnt_sat) begin
                cnt <= cnt + 6'd1;
            end

            state <= state_next;

            if (cmd_shift) begin
                cmd_sr <= {cmd_sr[6:0], rx_bit};
            end

            if (bcnt_clr) begin
                bcnt <= '0;
            end else if (bcnt_inc) begin
                bcnt <= bcnt + 5'd1;
            end

            if (tcnt_clr) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 8'd1;
            end

            // BTN_DATA is captured only here; later changes cannot alter a
            // reply already in flight.
            if (load_info) begin
                tx_sr   <= INFO_WORD;
                tx_info <= 1'b1;
            end else if (load_poll) begin
                tx_sr   <= btn_rev;
                tx_info <= 1'b0;
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[30:0], 1'b0};
            end

            CMD_STB <= stb_next;
            if (stb_next) begin
                CMD <= cmd_sr;
            end

            CTRL_OE <= oe_next;
            BUSY    <= busy_next;
        end
    end

endmodule

// File: tb/tb_n64_ctrl_responder.sv
// -----------------------------------------------------------------------------
// tb_n64_ctrl_responder
//
// Directed bench for n64_ctrl_responder. A console model drives the joybus
// line through a wired-AND with the responder's open-drain output. A monitor
// records every low pulse and high gap the responder produces, plus the
// cycle stamps of CMD_STB, BUSY and CTRL_OE, and the main sequence compares
// them with hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_n64_ctrl_responder;

    localparam int RESP_DELAY = 8;

    logic        clk;
    logic        rst;
    logic        drv;
    logic        ctrl_line;
    logic        ctrl_oe;
    logic        en;
    logic [31:0] btn_data;
    logic [7:0]  cmd;
    logic        cmd_stb;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    // Open-drain bus: either side can pull low.
    assign ctrl_line = drv & ~ctrl_oe;

    n64_ctrl_responder #(
        .RESP_DELAY (RESP_DELAY),
        .IDLE_MIN   (16),
        .STATUS_BYTE(8'h02)
    ) dut (
        .CLK_4M  (clk),
        .RST     (rst),
        .CTRL_IN (ctrl_line),
        .CTRL_OE (ctrl_oe),
        .EN      (en),
        .BTN_DATA(btn_data),
        .CMD     (cmd),
        .CMD_STB (cmd_stb),
        .BUSY    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the DUT's active edge
    // ---------------------------------------------------------------------
    int clr_gen = 0;
    int gen_seen = 0;
    int cyc = 0;
    int stb_count = 0;
    int stb_cyc = 0;
    int first_oe_cyc = -1;
    int busy_rise_cyc = 0;
    int busy_fall_cyc = 0;
    int oe_fall_cyc = 0;
    int oe_total = 0;
    int busy_total = 0;
    int oe_run = 0;
    int gap_run = 0;
    bit busy_done = 1'b0;
    bit oe_prev = 1'b0;
    bit busy_prev = 1'b0;
    int pulses[$];
    int gaps[$];

    initial begin
        forever begin
            @(negedge clk);
            if (clr_gen != gen_seen) begin
                gen_seen     = clr_gen;
                stb_count    = 0;
                stb_cyc      = 0;
                first_oe_cyc = -1;
                busy_rise_cyc = 0;
                busy_fall_cyc = 0;
                oe_fall_cyc  = 0;
                oe_total     = 0;
                busy_total   = 0;
                oe_run       = 0;
                gap_run      = 0;
                busy_done    = 1'b0;
                pulses.delete();
                gaps.delete();
            end
            if (cmd_stb) begin
                stb_count++;
                stb_cyc = cyc;
            end
            if (ctrl_oe) begin
                oe_total++;
                oe_run++;
                if (!oe_prev) begin
                    if (first_oe_cyc < 0) first_oe_cyc = cyc;
                    if (gap_run > 0) gaps.push_back(gap_run);
                    gap_run = 0;
                end
            end else begin
                if (oe_prev) begin
                    pulses.push_back(oe_run);
                    oe_run      = 0;
                    oe_fall_cyc = cyc;
                end
                if (busy) gap_run++;
            end
            if (busy) busy_total++;
            if (busy && !busy_prev) busy_rise_cyc = cyc;
            if (!busy && busy_prev) begin
                busy_fall_cyc = cyc;
                busy_done     = 1'b1;
            end
            oe_prev   = ctrl_oe;
            busy_prev = busy;
            cyc++;
        end
    end

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        clr_gen++;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // NOTE: the console model changes the line with blocking assignments on
    // the falling clock edge, half a cycle clear of the DUT's sampling edge.
    task automatic send_bit(input bit b);
        drv = 1'b0;
        repeat (b ? 4 : 12) @(negedge clk);
        drv = 1'b1;
        repeat (b ? 12 : 4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_stop();
        drv = 1'b0;
        repeat (4) @(negedge clk);
        drv = 1'b1;
    endtask

    task automatic send_cmd(input logic [7:0] v);
        send_byte(v);
        send_stop();
    endtask

    task automatic wait_busy_rise(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
    endtask

    task automatic wait_done(input int limit, output bit ok);
        for (int i = 0; i < limit && !busy_done; i++) @(negedge clk);
        ok = busy_done;
    endtask

    int exp_pulses[$];
    int exp_gaps[$];

    // Expected wire image: '1' = 4 low / 12 high, '0' = 12 low / 4 high,
    // then an 8-cycle stop pulse with no trailing gap inside BUSY.
    task automatic build_expect(input logic [31:0] word, input int nbits, input bit lsb_first);
        bit b;
        exp_pulses.delete();
        exp_gaps.delete();
        for (int i = 0; i < nbits; i++) begin
            b = lsb_first ? word[i] : word[nbits - 1 - i];
            exp_pulses.push_back(b ? 4 : 12);
            exp_gaps.push_back(b ? 12 : 4);
        end
        exp_pulses.push_back(8);
    endtask

    task automatic check_reply(input string tag, input int span);
        int mism;
        check({tag, "_stb_count"}, stb_count, 1);
        check({tag, "_oe_latency"}, first_oe_cyc - stb_cyc, RESP_DELAY);
        check({tag, "_busy_rise"}, busy_rise_cyc, first_oe_cyc);
        check({tag, "_busy_span"}, busy_fall_cyc - busy_rise_cyc, span);
        check({tag, "_busy_total"}, busy_total, span);
        check({tag, "_release"}, oe_fall_cyc, busy_fall_cyc);
        check({tag, "_pulse_count"}, pulses.size(), exp_pulses.size());
        mism = 0;
        for (int i = 0; i < exp_pulses.size(); i++)
            if (i >= pulses.size() || pulses[i] != exp_pulses[i]) mism++;
        check({tag, "_pulse_bad"}, mism, 0);
        check({tag, "_gap_count"}, gaps.size(), exp_gaps.size());
        mism = 0;
        for (int i = 0; i < exp_gaps.size(); i++)
            if (i >= gaps.size() || gaps[i] != exp_gaps[i]) mism++;
        check({tag, "_gap_bad"}, mism, 0);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        bit ok;

        rst      = 1'b1;
        drv      = 1'b1;
        en       = 1'b1;
        btn_data = 32'h0;
        @(negedge clk);
        idle(3);

        // Reset state
        check("rst_oe", ctrl_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stb", cmd_stb, 1'b0);
        check("rst_cmd", cmd, 8'h00);
        rst = 1'b0;
        idle(40);

        // Poll, A pressed; button word changed mid-reply must not matter
        btn_data = 32'h0000_0001;
        build_expect(32'h0000_0001, 32, 1'b1);
        clear_monitor();
        send_cmd(8'h01);
        wait_busy_rise(60, ok);
        check("poll_start", ok, 1'b1);
        btn_data = 32'hFFFF_FFFF;
        wait_done(700, ok);
        check("poll_done", ok, 1'b1);
        check("poll_cmd", cmd, 8'h01);
        check_reply("poll", 520);
        idle(40);

        // Info / reset command 0xFF -> 05 00 02
        clear_monitor();
        build_expect(32'h0005_0002, 24, 1'b0);
        send_cmd(8'hFF);
        wait_done(700, ok);
        check("info_done", ok, 1'b1);
        check("info_cmd", cmd, 8'hFF);
        check_reply("info", 392);
        idle(40);

        // Pak read 0x02 + 16 address bits: strobed, never answered
        clear_monitor();
        send_byte(8'h02);
        for (int i = 15; i >= 0; i--) send_bit(i[0] ^ i[2]);
        send_stop();
        idle(30);
        check("pak_stb_count", stb_count, 1);
        check("pak_cmd", cmd, 8'h02);
        check("pak_oe_total", oe_total, 0);
        check("pak_busy_total", busy_total, 0);

        // Following poll after a long enough idle is answered
        btn_data = 32'h8000_0000;
        build_expect(32'h8000_0000, 32, 1'b1);
        clear_monitor();
        send_cmd(8'h01);
        wait_done(700, ok);
        check("pak_poll_done", ok, 1'b1);
        check("pak_poll_cmd", cmd, 8'h01);
        check_reply("pak_poll", 520);
        idle(40);

        // Console stops after 5 bits: timeout, no strobe, no drive
        clear_monitor();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        idle(100);
        check("tmo_stb_count", stb_count, 0);
        check("tmo_oe_total", oe_total, 0);

        // Next valid poll answered normally
        btn_data = 32'h1234_5678;
        build_expect(32'h1234_5678, 32, 1'b1);
        clear_monitor();
        send_cmd(8'h01);
        wait_done(700, ok);
        check("tmo_poll_done", ok, 1'b1);
        check("tmo_poll_cmd", cmd, 8'h01);
        check_reply("tmo_poll", 520);
        idle(40);

        // Bus conflict: falling edge injected early in DELAY
        clear_monitor();
        send_cmd(8'h01);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (cmd_stb) ok = 1'b1;
        end
        check("cfl_stb_seen", ok, 1'b1);
        idle(2);
        drv = 1'b0;
        idle(4);
        drv = 1'b1;
        idle(100);
        check("cfl_stb_count", stb_count, 1);
        check("cfl_oe_total", oe_total, 0);
        check("cfl_busy_total", busy_total, 0);
        idle(40);

        // Reset during reply bit 10 (all-zero word: bit 10 is low 12 cycles)
        btn_data = 32'h0;
        clear_monitor();
        send_cmd(8'h01);
        wait_busy_rise(60, ok);
        check("rst_tx_start", ok, 1'b1);
        idle(16 * 10 + 5);
        check("rst_tx_oe_before", ctrl_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx_oe", ctrl_oe, 1'b0);
        check("rst_tx_busy", busy, 1'b0);
        check("rst_tx_stb", cmd_stb, 1'b0);
        check("rst_tx_cmd", cmd, 8'h00);
        rst = 1'b0;
        idle(40);

        // EN = 0: decode and strobe only
        en = 1'b0;
        clear_monitor();
        send_cmd(8'h01);
        idle(100);
        check("en0_stb_count", stb_count, 1);
        check("en0_cmd", cmd, 8'h01);
        check("en0_oe_total", oe_total, 0);
        en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
